spi_slave_capture: RTL

SPI_SLAVE_CAPTURE -- requirements
Module: spi_slave_capture

---
 rtl/spi_slave_capture.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_capture.sv
// SPI slave capture: synchronises an external SPI bus into pclk, shifts in
// full-duplex MOSI/MISO words and queues them as bit-order-normalised pairs.
module spi_slave_capture #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          pclk,
    input  logic                          areset,
    input  logic                          cfg_cpol,
    input  logic                          cfg_cpha,
    input  logic                          cfg_lsb_first,
    input  logic                          sclk,
    input  logic                          cs,
    input  logic                          mosi0,
    input  logic                          miso0,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_mosi,
    output logic [DATA_WIDTH-1:0]         out_miso,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_abort
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] miso_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    logic sclk_s, cs_s, mosi_s, miso_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    state_t                state_q, state_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shm_q, shm_d;
    logic [DATA_WIDTH-1:0] shs_q, shs_d;
    logic                  abort_q, abort_d;
    logic                  push;
    logic                  sample_edge;
    logic                  word_done;

    logic [DATA_WIDTH-1:0] mem_mosi_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_miso_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  ovf_q;
    logic                  pop, full, push_ok;

    // Synchroniser reset values make an idle bus look like sclk=0, cs=1.
    always_ff @(posedge pclk) begin
        if (areset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            miso_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi0};
            miso_sync_q <= {miso_sync_q[SYNC_STAGES-2:0], miso0};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign miso_s    = miso_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    assign sample_edge = (cpol_q ^ cpha_q) ? sclk_fall : sclk_rise;
    assign word_done   = (cnt_q == CW'(DATA_WIDTH));

    always_ff @(posedge pclk) begin
        if (areset) begin
            state_q <= IDLE;
            cpol_q  <= 1'b0;
            cpha_q  <= 1'b0;
            lsb_q   <= 1'b0;
            cnt_q   <= '0;
            shm_q   <= '0;
            shs_q   <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cpol_q  <= cpol_d;
            cpha_q  <= cpha_d;
            lsb_q   <= lsb_d;
            cnt_q   <= cnt_d;
            shm_q   <= shm_d;
            shs_q   <= shs_d;
            abort_q <= abort_d;
        end
    end

    // A full word is pushed one cycle after its last bit; the slow sclk
    // guarantees no sampling edge lands in that push cycle.
    always_comb begin
        state_d = state_q;
        cpol_d  = cpol_q;
        cpha_d  = cpha_q;
        lsb_d   = lsb_q;
        cnt_d   = cnt_q;
        shm_d   = shm_q;
        shs_d   = shs_q;
        abort_d = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cs_fall) begin
                    state_d = ACTIVE;
                    cpol_d  = cfg_cpol;
                    cpha_d  = cfg_cpha;
                    lsb_d   = cfg_lsb_first;
                    shm_d   = '0;
                    shs_d   = '0;
                end
            end
            ACTIVE: begin
                if (word_done) begin
                    push  = 1'b1;
                    cnt_d = '0;
                end else if (sample_edge) begin
                    if (lsb_q) begin
                        shm_d = {mosi_s, shm_q[DATA_WIDTH-1:1]};
                        shs_d = {miso_s, shs_q[DATA_WIDTH-1:1]};
                    end else begin
                        shm_d = {shm_q[DATA_WIDTH-2:0], mosi_s};
                        shs_d = {shs_q[DATA_WIDTH-2:0], miso_s};
                    end
                    cnt_d = cnt_q + CW'(1);
                end
                if (cs_rise) begin
                    state_d = IDLE;
                    abort_d = !word_done && (cnt_q != '0);
                    cnt_d   = '0;
                    shm_d   = '0;
                    shs_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop     = out_valid & out_ready;
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign push_ok = push & (~full | pop);

    always_ff @(posedge pclk) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            if (push_ok && !pop)      count_q <= count_q + (AW+1)'(1);
            else if (!push_ok && pop) count_q <= count_q - (AW+1)'(1);
            if (push && full && !pop) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (push_ok) begin
            mem_mosi_q[wr_ptr_q] <= shm_q;
            mem_miso_q[wr_ptr_q] <= shs_q;
        end
    end

    // Head data is gated so the outputs read zero whenever the FIFO is empty.
    assign out_valid   = (count_q != '0);
    assign out_mosi    = out_valid ? mem_mosi_q[rd_ptr_q] : '0;
    assign out_miso    = out_valid ? mem_miso_q[rd_ptr_q] : '0;
    assign fifo_count  = count_q;
    assign overflow    = ovf_q;
    assign frame_abort = abort_q;

endmodule
